// File: rtl/run_monitor_pkg.sv
// run_monitor shared types: FSM states, counter and index widths.
// Stall detection is enabled with RUN_MONITOR_STALL_DETECT_EN.
package run_monitor_pkg;

  localparam int CNT_W = 32;
  localparam int IDX_W = 16;

  typedef enum logic [2:0] {
    S_RUN,
    S_DUMP_REQ,
    S_DUMP_WAIT,
    S_DUMP_HOLD,
    S_DONE
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/run_monitor_if.sv
// Memory read port and dump stream of the run monitor.
// master = monitor side, slave = memory / dump consumer side.
interface run_monitor_if;
  import run_monitor_pkg::*;

  logic             mem_rd_en;
  logic [31:0]      mem_rd_addr;
  logic [31:0]      mem_rd_data;
  logic             dump_valid;
  logic             dump_ready;
  logic [31:0]      dump_data;
  logic [IDX_W-1:0] dump_index;

  modport master (
    output mem_rd_en,
    output mem_rd_addr,
    input  mem_rd_data,
    output dump_valid,
    input  dump_ready,
    output dump_data,
    output dump_index
  );

  modport slave (
    input  mem_rd_en,
    input  mem_rd_addr,
    output mem_rd_data,
    input  dump_valid,
    output dump_ready,
    input  dump_data,
    input  dump_index
  );

endinterface

// File: rtl/run_monitor_cmp.sv
// N-way masked equality of pc against packed end addresses.
module run_monitor_cmp #(
  parameter int N = 2
) (
  input  logic [31:0]     pc_i,
  input  logic [32*N-1:0] end_pc_i,
  input  logic [N-1:0]    en_i,
  output logic            hit_o
);

  always_comb begin
    hit_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (en_i[k] && pc_i == end_pc_i[32*k +: 32])
        hit_o = 1'b1;
    end
  end

endmodule

// File: rtl/run_monitor.sv
// Watches a core's pc, ends the run on end-pc/timeout, dumps memory.
// Optional pc-stall end detection: RUN_MONITOR_STALL_DETECT_EN.
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int NUM_END_PC     = 2,
  parameter int DUMP_BASE      = 12,
  parameter int DUMP_WORDS     = 96,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int STALL_CYCLES   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             pc,
  input  logic                    pc_valid,
  input  logic [32*NUM_END_PC-1:0] end_pc,
  input  logic [NUM_END_PC-1:0]   end_pc_en,
  run_monitor_if.master           bus,
  output logic                    done,
  output logic                    timed_out,
  output logic [CNT_W-1:0]        cycle_count,
  output logic [CNT_W-1:0]        instr_count
);

  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               TO_EN  = TIMEOUT_CYCLES != 0;
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(DUMP_WORDS - 1);
  localparam logic [31:0]      BASE   = 32'(DUMP_BASE);

  if (DUMP_WORDS < 1 || STALL_CYCLES < 1) begin : g_bad_cfg
    $error("run_monitor: DUMP_WORDS and STALL_CYCLES must be >= 1");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      data_q, data_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ins_q, ins_d;
  logic             to_q, to_d;
  logic             cmp_hit;
  logic             end_hit;

  run_monitor_cmp #(
    .N (NUM_END_PC)
  ) u_cmp (
    .pc_i     (pc),
    .end_pc_i (end_pc),
    .en_i     (end_pc_en),
    .hit_o    (cmp_hit)
  );

`ifdef RUN_MONITOR_STALL_DETECT_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [31:0]      pc_last_q;

  // first cycle on a new pc counts as 1
  always_comb begin
    stall_d = (pc == pc_last_q) ? sat_inc(stall_q) : CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q   <= '0;
      pc_last_q <= '0;
    end else if (state_q == S_RUN) begin
      stall_q   <= stall_d;
      pc_last_q <= pc;
    end
  end

  assign end_hit = (pc_valid && cmp_hit) ||
                   (stall_d == CNT_W'(STALL_CYCLES));
`else
  assign end_hit = pc_valid && cmp_hit;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RUN;
      idx_q   <= '0;
      data_q  <= '0;
      cyc_q   <= '0;
      ins_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      cyc_q   <= cyc_d;
      ins_q   <= ins_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    cyc_d   = cyc_q;
    ins_d   = ins_q;
    to_d    = to_q;
    unique case (state_q)
      S_RUN: begin
        cyc_d = sat_inc(cyc_q);
        if (pc_valid)
          ins_d = sat_inc(ins_q);
        // an end hit in the timeout cycle wins
        if (end_hit) begin
          state_d = S_DUMP_REQ;
        end else if (TO_EN && cyc_d == TO_LIM) begin
          to_d    = 1'b1;
          state_d = S_DUMP_REQ;
        end
      end
      S_DUMP_REQ: state_d = S_DUMP_WAIT;
      S_DUMP_WAIT: begin
        data_d  = bus.mem_rd_data;
        state_d = S_DUMP_HOLD;
      end
      S_DUMP_HOLD: begin
        if (bus.dump_ready) begin
          if (idx_q == LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_DUMP_REQ;
          end
        end
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    bus.mem_rd_en   = 1'b0;
    bus.mem_rd_addr = '0;
    bus.dump_valid  = 1'b0;
    done            = 1'b0;
    unique case (1'b1)
      state_q == S_DUMP_REQ: begin
        bus.mem_rd_en   = 1'b1;
        bus.mem_rd_addr = BASE + 32'(idx_q);
      end
      state_q == S_DUMP_HOLD: bus.dump_valid = 1'b1;
      state_q == S_DONE:      done = 1'b1;
      default: ;
    endcase
    bus.dump_data  = data_q;
    bus.dump_index = idx_q;
    timed_out      = to_q;
    cycle_count    = cyc_q;
    instr_count    = ins_q;
  end

endmodule

// File: tb/tb_run_monitor.sv
// Self-checking bench for run_monitor (TIMEOUT_CYCLES=50).
// Define RUN_MONITOR_STALL_DETECT_EN to also exercise stall ends.
module tb_run_monitor;

  localparam int BASE  = 12;
  localparam int WORDS = 96;
  localparam int TMO   = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        pc_valid;
  logic [63:0] end_pc;
  logic [1:0]  end_pc_en;
  logic        done;
  logic        timed_out;
  logic [31:0] cycle_count;
  logic [31:0] instr_count;
  logic [31:0] mem_off = '0;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  run_monitor_if bus ();

  run_monitor #(
    .NUM_END_PC     (2),
    .DUMP_BASE      (BASE),
    .DUMP_WORDS     (WORDS),
    .TIMEOUT_CYCLES (TMO),
    .STALL_CYCLES   (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .end_pc      (end_pc),
    .end_pc_en   (end_pc_en),
    .bus         (bus),
    .done        (done),
    .timed_out   (timed_out),
    .cycle_count (cycle_count),
    .instr_count (instr_count)
  );

  // memory word at address a holds a + mem_off, 1-cycle latency
  always @(posedge clk)
    bus.mem_rd_data <= bus.mem_rd_en ?
      bus.mem_rd_addr + mem_off : 32'hDEADBEEF;

  typedef struct {
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  en;
    int          cyc;
    logic        to;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset          = 1'b1;
    pc             = '0;
    pc_valid       = 1'b0;
    bus.dump_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"},  32'(bus.mem_rd_en), 0);
    chk({tag, "_rd_addr"}, bus.mem_rd_addr, 0);
    chk({tag, "_valid"},  32'(bus.dump_valid), 0);
    chk({tag, "_data"},   bus.dump_data, 0);
    chk({tag, "_index"},  32'(bus.dump_index), 0);
    chk({tag, "_done"},   32'(done), 0);
    chk({tag, "_to"},     32'(timed_out), 0);
    chk({tag, "_cyc"},    cycle_count, 0);
    chk({tag, "_ins"},    instr_count, 0);
  endtask

  // pc = 4n with pc_valid each cycle; returns cycles spent in RUN
  task automatic run_linear(output int ncyc);
    ncyc = -1;
    for (int n = 0; n < 200; n++) begin
      pc       = 32'(4 * n);
      pc_valid = 1'b1;
      step();
      if (bus.mem_rd_en) begin
        ncyc = n + 1;
        break;
      end
    end
    pc_valid = 1'b0;
    if (ncyc < 0) chk("run_bound", 1, 0);
  endtask

  // entered with DUMP_REQ just sampled
  task automatic dump(input int stall_word,
                      input bit rnd,
                      input int abort_at,
                      output int steps);
    int nxt  = 0;
    int rds  = 0;
    int held = 0;
    logic [31:0] exp;
    steps = 0;
    bus.dump_ready = 1'b1;
    while (!done && steps < 2000) begin
      if (bus.mem_rd_en) begin
        rds++;
        chk("rd_addr", bus.mem_rd_addr, 32'(BASE + nxt));
      end
      if (bus.dump_valid) begin
        exp = 32'(BASE + nxt) + mem_off;
        chk("dump_index", 32'(bus.dump_index), 32'(nxt));
        chk("dump_data", bus.dump_data, exp);
        if (nxt == abort_at) return;
        if (nxt == stall_word && held < 10) begin
          bus.dump_ready = 1'b0;
          held++;
        end else begin
          bus.dump_ready = rnd ? 1'($urandom % 2) : 1'b1;
        end
        if (bus.dump_ready) nxt++;
      end
      step();
      steps++;
    end
    chk("dump_words", 32'(nxt), WORDS);
    chk("dump_reads", 32'(rds), WORDS);
    chk("done", 32'(done), 1);
    chk("done_valid", 32'(bus.dump_valid), 0);
    chk("done_rd_en", 32'(bus.mem_rd_en), 0);
  endtask

  initial begin
    int ncyc;
    int steps;
    logic [31:0] e0, e1, pcv, prev;
    logic [1:0]  en;
    logic        pv, hit;
    int          mcyc, mins;
    bit          ended;

    tbl[0] = '{32'h20, 32'h30, 2'b11,  9, 1'b0};
    tbl[1] = '{32'h20, 32'h30, 2'b10, 13, 1'b0};
    tbl[2] = '{32'h20, 32'h30, 2'b00, 50, 1'b1};
    tbl[3] = '{32'hC4, 32'h00, 2'b01, 50, 1'b0};
    tbl[4] = '{32'h30, 32'h00, 2'b10,  1, 1'b0};

    end_pc    = '0;
    end_pc_en = '0;
    apply_reset();
    chk_zero("rst");

    foreach (tbl[i]) begin
      end_pc    = {tbl[i].e1, tbl[i].e0};
      end_pc_en = tbl[i].en;
      apply_reset();
      run_linear(ncyc);
      chk("tbl_len", 32'(ncyc), 32'(tbl[i].cyc));
      chk("tbl_to", 32'(timed_out), 32'(tbl[i].to));
      chk("tbl_cyc", cycle_count, 32'(tbl[i].cyc));
      chk("tbl_ins", instr_count, 32'(tbl[i].cyc));
      pc_valid = 1'b1;
      step();
      chk("tbl_frz_cyc", cycle_count, 32'(tbl[i].cyc));
      chk("tbl_frz_ins", instr_count, 32'(tbl[i].cyc));
    end

    // full dump, then dump with backpressure on word 5
    end_pc    = {32'h30, 32'h20};
    end_pc_en = 2'b11;
    for (int s = 0; s < 2; s++) begin
      apply_reset();
      run_linear(ncyc);
      chk("dump_len", 32'(ncyc), 9);
      dump(s == 0 ? -1 : 5, 1'b0, -1, steps);
      chk("dump_steps", 32'(steps), 32'(3 * WORDS + 10 * s));
    end

    // async reset during word 40, then rerun from index 0
    apply_reset();
    run_linear(ncyc);
    dump(-1, 1'b0, 40, steps);
    #1 reset = 1'b1;
    #1 chk_zero("midrst");
    apply_reset();
    run_linear(ncyc);
    chk("rerun_ins", instr_count, 9);
    dump(-1, 1'b0, -1, steps);

`ifdef RUN_MONITOR_STALL_DETECT_EN
    end_pc_en = 2'b00;
    apply_reset();
    ncyc = -1;
    pc = 32'h1C;
    pc_valid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      step();
      if (bus.mem_rd_en) begin
        ncyc = n + 1;
        break;
      end
    end
    pc_valid = 1'b0;
    chk("stall_len", 32'(ncyc), 16);
    chk("stall_to", 32'(timed_out), 0);
    chk("stall_cyc", cycle_count, 16);
`endif

    // random runs against a rule-level reference model
    for (int r = 0; r < 25; r++) begin
      mem_off   = $urandom;
      e0        = 32'(4 * $urandom_range(0, 15));
      e1        = 32'(4 * $urandom_range(0, 15));
      en        = 2'($urandom % 4);
      end_pc    = {e1, e0};
      end_pc_en = en;
      apply_reset();
      prev  = 32'hFFFF_FFFF;
      mcyc  = 0;
      mins  = 0;
      ended = 1'b0;
      for (int n = 0; n < 200 && !ended; n++) begin
        do pcv = 32'(4 * $urandom_range(0, 15));
        while (pcv == prev);
        prev     = pcv;
        pv       = ($urandom % 4) != 0;
        pc       = pcv;
        pc_valid = pv;
        step();
        mcyc++;
        if (pv) mins++;
        hit = pv && ((en[0] && pcv == e0) ||
                     (en[1] && pcv == e1));
        if (hit || mcyc == TMO) begin
          ended = 1'b1;
          chk("rnd_end", 32'(bus.mem_rd_en), 1);
          chk("rnd_to", 32'(timed_out), 32'(!hit));
          chk("rnd_cyc", cycle_count, 32'(mcyc));
          chk("rnd_ins", instr_count, 32'(mins));
        end else if (bus.mem_rd_en) begin
          chk("rnd_early", 32'(bus.mem_rd_en), 0);
        end
      end
      pc_valid = 1'b0;
      if (bus.mem_rd_en) dump(-1, 1'b1, -1, steps);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
